// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 window filter datapath.
package filter_pkg;

    typedef enum logic [1:0] {
        LAPL4 = 2'd0,
        LAPL8 = 2'd1,
        GAUSS = 2'd2,
        AVG   = 2'd3
    } kernel_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } ctrl_state_e;

    localparam int WIN_DIM = 3;

endpackage

// File: rtl/filter_line_buf.sv
// One line of pixel storage: synchronous write, combinational read.
module filter_line_buf #(
    parameter int p_data_bw   = 10,
    parameter int p_max_width = 1024,
    localparam int aw = (p_max_width > 1) ? $clog2(p_max_width) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [aw-1:0]        i_addr,
    input  logic [p_data_bw-1:0] i_wdata,
    output logic [p_data_bw-1:0] o_rdata
);

    logic [p_data_bw-1:0] mem [p_max_width];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    // Read-before-write: a same-address write lands after this read is used.
    assign o_rdata = mem[i_addr];

endmodule

// File: rtl/filter_window_ctrl.sv
// Frame sequencer: buffers two lines, assembles 3x3 windows and holds the
// kernel selection for the whole frame.
module filter_window_ctrl
    import filter_pkg::*;
#(
    parameter int p_data_bw   = 10,
    parameter int p_win_size  = 9,
    parameter int p_max_width = 1024,
    localparam int lw = $clog2(p_max_width + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_start,
    input  logic [1:0]           i_cfg_kernel,
    input  logic [lw-1:0]        i_cfg_width,
    input  logic [lw-1:0]        i_cfg_height,
    output logic [p_data_bw-1:0] o_filter_config,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_err_cfg,
    input  logic                 i_dxi_in_valid,
    output logic                 o_dxi_in_ready,
    input  logic [p_data_bw-1:0] i_dxi_in_data,
    output logic                 o_dxi_out_valid,
    input  logic                 i_dxi_out_ready,
    output logic [p_data_bw-1:0] o_dxi_out_data [p_win_size]
);

    localparam int aw = (p_max_width > 1) ? $clog2(p_max_width) : 1;
    localparam logic [lw-1:0] MIN_DIM = lw'(WIN_DIM);
    localparam logic [lw-1:0] MAX_W   = lw'(p_max_width);

    ctrl_state_e          state_q, state_d;
    kernel_e              kernel_r;
    logic [lw-1:0]        width_r, height_r, x_q, y_q;
    logic                 err_q, done_q, vld_p0;
    logic [p_data_bw-1:0] win_p0 [p_win_size];
    logic [p_data_bw-1:0] lb0_rd, lb1_rd;
    logic                 cfg_ok, start_ok, start_bad, drain_exit;
    logic                 accept, emit, last_px;

    assign cfg_ok = (i_cfg_width >= MIN_DIM) && (i_cfg_height >= MIN_DIM) &&
                    (i_cfg_width <= MAX_W);
    assign o_dxi_in_ready = (state_q == RUN) && (!vld_p0 || i_dxi_out_ready);
    assign accept  = i_dxi_in_valid && o_dxi_in_ready;
    assign emit    = accept && (x_q >= lw'(2)) && (y_q >= lw'(2));
    assign last_px = (x_q == width_r - lw'(1)) && (y_q == height_r - lw'(1));

    always_comb begin
        state_d    = state_q;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        drain_exit = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    start_ok  = cfg_ok;
                    start_bad = !cfg_ok;
                    if (cfg_ok) state_d = RUN;
                end
            end
            RUN: begin
                if (accept && last_px) state_d = DRAIN;
            end
            DRAIN: begin
                if (!vld_p0 || i_dxi_out_ready) begin
                    drain_exit = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            kernel_r <= LAPL4;
            width_r  <= '0;
            height_r <= '0;
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            err_q  <= start_bad;
            done_q <= drain_exit;
            if (start_ok) begin
                kernel_r <= kernel_e'(i_cfg_kernel);
                width_r  <= i_cfg_width;
                height_r <= i_cfg_height;
                x_q      <= '0;
                y_q      <= '0;
            end else if (accept) begin
                if (x_q == width_r - lw'(1)) begin
                    x_q <= '0;
                    y_q <= y_q + lw'(1);
                end else begin
                    x_q <= x_q + lw'(1);
                end
            end
        end
    end

    // Stage p0: window shift on accept; the new right column is {lb1, lb0, pixel}.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < p_win_size; i++) win_p0[i] <= '0;
            vld_p0 <= 1'b0;
        end else begin
            if (accept) begin
                for (int r = 0; r < WIN_DIM; r++) begin
                    win_p0[r*WIN_DIM]     <= win_p0[r*WIN_DIM + 1];
                    win_p0[r*WIN_DIM + 1] <= win_p0[r*WIN_DIM + 2];
                end
                win_p0[WIN_DIM - 1]   <= lb1_rd;
                win_p0[2*WIN_DIM - 1] <= lb0_rd;
                win_p0[3*WIN_DIM - 1] <= i_dxi_in_data;
            end
            if (emit)                 vld_p0 <= 1'b1;
            else if (i_dxi_out_ready) vld_p0 <= 1'b0;
        end
    end

    filter_line_buf #(.p_data_bw(p_data_bw), .p_max_width(p_max_width)) lb0 (
        .i_clk  (i_clk),
        .i_we   (accept),
        .i_addr (x_q[aw-1:0]),
        .i_wdata(i_dxi_in_data),
        .o_rdata(lb0_rd)
    );

    filter_line_buf #(.p_data_bw(p_data_bw), .p_max_width(p_max_width)) lb1 (
        .i_clk  (i_clk),
        .i_we   (accept),
        .i_addr (x_q[aw-1:0]),
        .i_wdata(lb0_rd),
        .o_rdata(lb1_rd)
    );

    assign o_filter_config = {{(p_data_bw-2){1'b0}}, kernel_r};
    assign o_busy          = (state_q == RUN) || (state_q == DRAIN);
    assign o_frame_done    = done_q;
    assign o_err_cfg       = err_q;
    assign o_dxi_out_valid = vld_p0;
    assign o_dxi_out_data  = win_p0;

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Scoreboard bench for filter_window_ctrl: directed frames, rejects, stalls, reset.
module tb_filter_window_ctrl;

    localparam int DW = 10;
    localparam int WS = 9;
    localparam int MW = 1024;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [1:0]    i_cfg_kernel = '0;
    logic [LW-1:0] i_cfg_width = '0;
    logic [LW-1:0] i_cfg_height = '0;
    logic [DW-1:0] o_filter_config;
    logic          o_busy, o_frame_done, o_err_cfg;
    logic          i_dxi_in_valid = 1'b0;
    logic          o_dxi_in_ready;
    logic [DW-1:0] i_dxi_in_data = '0;
    logic          o_dxi_out_valid;
    logic          i_dxi_out_ready = 1'b0;
    logic [DW-1:0] o_dxi_out_data [WS];
    logic [89:0]   flat;

    filter_window_ctrl #(.p_data_bw(DW), .p_win_size(WS), .p_max_width(MW)) dut (
        .i_clk          (clk),
        .i_rstn         (rst_n),
        .i_start        (i_start),
        .i_cfg_kernel   (i_cfg_kernel),
        .i_cfg_width    (i_cfg_width),
        .i_cfg_height   (i_cfg_height),
        .o_filter_config(o_filter_config),
        .o_busy         (o_busy),
        .o_frame_done   (o_frame_done),
        .o_err_cfg      (o_err_cfg),
        .i_dxi_in_valid (i_dxi_in_valid),
        .o_dxi_in_ready (o_dxi_in_ready),
        .i_dxi_in_data  (i_dxi_in_data),
        .o_dxi_out_valid(o_dxi_out_valid),
        .i_dxi_out_ready(i_dxi_out_ready),
        .o_dxi_out_data (o_dxi_out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        flat = '0;
        for (int i = 0; i < WS; i++) flat[(8-i)*10 +: 10] = o_dxi_out_data[i];
    end

    logic [89:0] exp_q [$];
    int tests = 0, fails = 0;
    int win_cnt = 0, done_cnt = 0, err_cnt = 0, last_hs = 0;
    bit rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [89:0] mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {10'(a0), 10'(a1), 10'(a2), 10'(a3), 10'(a4), 10'(a5), 10'(a6), 10'(a7), 10'(a8)};
    endfunction

    function automatic logic [9:0] pix(input int x, input int y);
        return 10'((x * 37 + y * 101 + 5) % 1024);
    endfunction

    function automatic logic [89:0] ref_win(input int cx);
        logic [89:0] w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(8 - (r*3 + c))*10 +: 10] = pix(cx - 1 + c, r);
        return w;
    endfunction

    // Monitor: pops the scoreboard on every output handshake
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (o_frame_done) begin
                done_cnt++;
                chk("done_latency", 96'(cyc - last_hs), 96'd1);
            end
            if (o_err_cfg) err_cnt++;
            if (o_dxi_out_valid && i_dxi_out_ready) begin
                win_cnt++;
                last_hs = cyc;
                if (exp_q.size() == 0) chk("window_unexpected", 96'd1, 96'd0);
                else                   chk("window", 96'(flat), 96'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) i_dxi_out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic start_frame(input int k, input int w, input int h);
        i_start      = 1'b1;
        i_cfg_kernel = 2'(k);
        i_cfg_width  = LW'(w);
        i_cfg_height = LW'(h);
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_px(input int d);
        int n = 0;
        i_dxi_in_valid = 1'b1;
        i_dxi_in_data  = DW'(d);
        @(negedge clk);
        while (!o_dxi_in_ready) begin
            n++;
            if (n > 500) begin
                chk("in_ready_timeout", 96'd0, 96'd1);
                break;
            end
            tick();
            @(negedge clk);
        end
        tick();
        i_dxi_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", 96'(done_cnt), 96'(target));
        repeat (6) tick();
        chk("frame_done_single", 96'(done_cnt), 96'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [89:0] hold;
        int c0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 96'({o_dxi_in_ready, o_dxi_out_valid, o_busy, o_frame_done, o_err_cfg}), 96'd0);
        chk("reset_cfg", 96'(o_filter_config), 96'd0);
        chk("reset_data", 96'(flat), 96'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Frame 1: 4x4, kernel 2, output always ready
        i_dxi_out_ready = 1'b1;
        exp_q.push_back(mk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        exp_q.push_back(mk9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        exp_q.push_back(mk9(4, 5, 6, 8, 9, 10, 12, 13, 14));
        exp_q.push_back(mk9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        start_frame(2, 4, 4);
        @(negedge clk);
        chk("start_busy", 96'({o_busy, o_dxi_in_ready}), 96'd3);
        tick();
        c0 = cyc;
        for (int i = 0; i < 16; i++) send_px(i);
        chk("throughput_cycles", 96'(cyc - c0), 96'd16);
        wait_done(1);
        chk("f1_config", 96'(o_filter_config), 96'd2);
        chk("f1_windows", 96'(win_cnt), 96'd4);
        chk("f1_queue_empty", 96'(exp_q.size()), 96'd0);

        // Rejected starts: width too small, height too small, width too large
        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       start_frame(1, 2, 4);
                1:       start_frame(1, 4, 2);
                default: start_frame(1, 1025, 3);
            endcase
            @(negedge clk);
            chk("rej_err_pulse", 96'(o_err_cfg), 96'd1);
            chk("rej_idle", 96'({o_busy, o_dxi_in_ready}), 96'd0);
            chk("rej_config", 96'(o_filter_config), 96'd2);
            tick();
            @(negedge clk);
            chk("rej_err_clear", 96'(o_err_cfg), 96'd0);
            tick();
        end
        chk("rej_err_count", 96'(err_cnt), 96'd3);

        // Frame 2: backpressure and an ignored mid-frame start
        i_dxi_out_ready = 1'b0;
        exp_q.push_back(mk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        exp_q.push_back(mk9(1, 2, 3, 5, 6, 7, 9, 10, 11));
        exp_q.push_back(mk9(4, 5, 6, 8, 9, 10, 12, 13, 14));
        exp_q.push_back(mk9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        start_frame(2, 4, 4);
        for (int i = 0; i < 11; i++) begin
            send_px(i);
            if (i == 5) begin
                start_frame(1, 4, 4);
                @(negedge clk);
                chk("midframe_config", 96'(o_filter_config), 96'd2);
                chk("midframe_busy", 96'(o_busy), 96'd1);
                tick();
            end
        end
        @(negedge clk);
        chk("bp_valid", 96'(o_dxi_out_valid), 96'd1);
        hold = flat;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("bp_in_ready", 96'(o_dxi_in_ready), 96'd0);
            chk("bp_data_stable", 96'(flat), 96'(hold));
        end
        tick();
        i_dxi_out_ready = 1'b1;
        for (int i = 11; i < 16; i++) send_px(i);
        wait_done(2);
        chk("f2_windows", 96'(win_cnt), 96'd8);
        chk("f2_queue_empty", 96'(exp_q.size()), 96'd0);
        chk("f2_config", 96'(o_filter_config), 96'd2);

        // Frame 3: aborted by reset after 7 pixels
        start_frame(3, 4, 4);
        for (int i = 0; i < 7; i++) send_px(i);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_ctrl", 96'({o_dxi_in_ready, o_dxi_out_valid, o_busy, o_frame_done, o_err_cfg}), 96'd0);
        chk("midreset_cfg", 96'(o_filter_config), 96'd0);
        chk("midreset_data", 96'(flat), 96'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("midreset_no_done", 96'(done_cnt), 96'd2);

        // Frame 4: fresh 3x3 yields a single window of all nine pixels
        exp_q.push_back(mk9(100, 137, 174, 211, 248, 285, 322, 359, 396));
        start_frame(0, 3, 3);
        for (int i = 0; i < 9; i++) send_px(100 + i * 37);
        wait_done(3);
        chk("f4_windows", 96'(win_cnt), 96'd9);
        chk("f4_config", 96'(o_filter_config), 96'd0);

        // Frame 5: maximum width with random stalls on both sides
        for (int cx = 1; cx <= MW - 2; cx++) exp_q.push_back(ref_win(cx));
        rnd_rdy = 1'b1;
        start_frame(3, MW, 3);
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < MW; x++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
                send_px(int'(pix(x, y)));
            end
        end
        rnd_rdy = 1'b0;
        i_dxi_out_ready = 1'b1;
        wait_done(4);
        chk("f5_windows", 96'(win_cnt), 96'(9 + MW - 2));
        chk("f5_queue_empty", 96'(exp_q.size()), 96'd0);
        chk("f5_config", 96'(o_filter_config), 96'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/filter_window_ctrl.md
# filter_window_ctrl

Frame-level sequencer for the 3x3 coefficient filter. Accepts a raster pixel stream over a dxi valid/ready handshake and buffers two lines. Assembles 3x3 windows and presents them to the filter's window input, holding the filter's kernel selection stable for a whole frame. Emits one window per interior pixel and pulses a done flag when the frame's last window has been consumed.

## Interface
- p_data_bw, 10, pixel width; also the width of the filter config port
- p_win_size, 9, window size; only 9 (3x3) is supported
- p_max_width, 1024, maximum line length in pixels; sets line-buffer depth
- lw (localparam), $clog2(p_max_width+1), width of the size and counter fields
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous, active-low reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_cfg_kernel  in  2  kernel select, latched at start: 0 Laplacian-4, 1 Laplacian-8, 2 Gaussian, 3 average
- i_cfg_width  in  lw  pixels per line, latched at start; legal range 3..p_max_width
- i_cfg_height  in  lw  lines per frame, latched at start; must be at least 3
- o_filter_config  out  p_data_bw  latched kernel, zero-extended; drives the filter config port
- o_busy  out  1  high in RUN and DRAIN
- o_frame_done  out  1  one-cycle pulse at end of frame
- o_err_cfg  out  1  one-cycle pulse when a start is rejected
- i_dxi_in_valid / o_dxi_in_ready / i_dxi_in_data[p_data_bw]  raster pixel input
- o_dxi_out_valid / i_dxi_out_ready / o_dxi_out_data[p_win_size][p_data_bw]  window output to the filter

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE + i_start:
  - Rejected when width<3, height<3 or width>p_max_width: o_err_cfg pulses and the block stays in IDLE. Nothing is latched.
  - Otherwise kernel, width and height are latched, counters x=y=0, and the block moves to RUN.
- i_start outside IDLE is ignored. o_filter_config holds its value until the next accepted start.
- o_dxi_in_ready = (state==RUN) && (!o_dxi_out_valid || i_dxi_out_ready). It is 0 in IDLE and DRAIN.
- On an accepted pixel p at column x, row y:
  - Shift the window left by one column.
  - The new right column is {lb1[x], lb0[x], p}: top, middle, bottom.
  - Update the line buffers: lb1[x] <= lb0[x], lb0[x] <= p.
  - If x = width-1, set x to 0 and increment y; otherwise increment x.
- Window layout: o_dxi_out_data[r*3+c], with row r=0 as the oldest line and column c=2 as the newest pixel. The window centre is pixel (x-1, y-1).
- A window is emitted only for accepted pixels with x>=2 and y>=2. Each frame produces exactly (W-2)*(H-2) windows; no border padding.
- o_dxi_out_data is driven directly from the window registers. Those registers change only on accept, which is gated as above, so data is stable while valid is high and unacknowledged.
- On acceptance of the last pixel (W-1, H-1), the block moves to DRAIN.
- In DRAIN, once o_dxi_out_valid is low or the output handshake completes:
  - o_frame_done pulses in the next cycle.
  - The block returns to IDLE in that same cycle.
- Line-buffer contents are never cleared. Rows 0 and 1 overwrite them before any window can use them.

## Timing
- Reset values:
  - All outputs are 0, including o_filter_config, o_dxi_out_valid and o_dxi_out_data.
  - State is IDLE and counters are 0.
- Reset mid-frame aborts the frame immediately. No o_frame_done is issued.
- From an accepted start to o_dxi_in_ready=1 takes one cycle: start is sampled in cycle N and the block is in RUN at N+1.
- Pixel accepted in cycle N gives o_dxi_out_valid=1 in cycle N+1 when that pixel produces a window.
- Throughput is one pixel per cycle with no stalls.
- Output valid clears the cycle after a handshake unless a new window is loaded in the same cycle.
- Simultaneous output handshake and input accept: the new window replaces the old one with no bubble.
- Line-buffer write and read at the same address x in the same cycle: the read returns the old value.

## Structure
- Package filter_pkg holds:
  - kernel_e: LAPL4=0, LAPL8=1, GAUSS=2, AVG=3.
  - ctrl_state_e: IDLE, RUN, DRAIN.
  - Constant WIN_DIM=3.
- Sub-module filter_line_buf: p_max_width x p_data_bw array with synchronous write and combinational read. It is instantiated twice, as lb0 and lb1.

## Test plan
- Basic frame:
  - Stimulus: 4x4 frame, pixel = y*4+x, kernel 2, output always ready.
  - Required: 4 windows. First window = {0,1,2,4,5,6,8,9,10}, last window = {5,6,7,9,10,11,13,14,15}, o_filter_config=2, o_frame_done one cycle after the 4th output handshake.
- Rejected start:
  - Stimulus: start with width=2.
  - Required: o_err_cfg pulses once, state stays IDLE, o_dxi_in_ready stays 0, o_filter_config unchanged.
- Backpressure:
  - Stimulus: hold i_dxi_out_ready low for 5 cycles while a window is pending.
  - Required: o_dxi_in_ready=0, o_dxi_out_data stable for those cycles, still exactly 4 windows, all correct.
- Start during a frame:
  - Stimulus: i_start with kernel 1 issued mid-frame.
  - Required: ignored, o_filter_config stays 2.
- Reset mid-frame:
  - Stimulus: assert i_rstn low after 7 pixels, then run a fresh 3x3 frame.
  - Required: all outputs 0 during reset. The new frame yields exactly 1 window, {p0..p8} in raster order, followed by o_frame_done.
- Maximum width:
  - Stimulus: 1024x3 frame with random stalls on both sides.
  - Required: 1022 windows matching the reference model, exactly one o_frame_done.
